// File: rtl/change_dispenser_pkg.sv
// ---------------------------------------------------------------------------
// change_dispenser_pkg
//
// Purpose : Shared definitions for the change dispenser block. Holds the
//           change-code constants sent by the vending FSM, the dispenser
//           state encoding, the default coin denomination and a helper
//           that turns a change code into an amount in tk.
//
// Contents:
//   COIN_TK        - default denomination (tk) of one hopper coin
//   R0/R5/R10/R15  - 2-bit change codes (0, 5, 10, 15 tk)
//   state_e        - dispenser FSM states
//   chg_to_tk()    - change code -> tk owed, for a given coin size
// ---------------------------------------------------------------------------
package change_dispenser_pkg;

    localparam int COIN_TK = 5;

    localparam logic [1:0] R0  = 2'b00;
    localparam logic [1:0] R5  = 2'b01;
    localparam logic [1:0] R10 = 2'b10;
    localparam logic [1:0] R15 = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RELEASE  = 3'd1,
        REQ      = 3'd2,
        WAIT_LOW = 3'd3,
        FAULT    = 3'd4
    } state_e;

    // The change code is also the number of coins to issue, so the amount
    // owed is simply code * coin size.
    function automatic logic [4:0] chg_to_tk(input logic [1:0] code,
                                             input int         coin_tk);
        logic [4:0] tk;
        case (code)
            R5:      tk = 5'(coin_tk);
            R10:     tk = 5'(2 * coin_tk);
            R15:     tk = 5'(3 * coin_tk);
            default: tk = '0;
        endcase
        return tk;
    endfunction

endpackage

// File: rtl/change_dispenser_ack_timer.sv
// ---------------------------------------------------------------------------
// ack_timer
//
// Purpose : Counts cycles spent waiting for the hopper to acknowledge a coin
//           request. Cleared when the dispenser enters its request state and
//           advanced every cycle it stays there. 'expired' flags the last
//           cycle the dispenser may wait before declaring a hopper fault.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous, active-low reset
//   clear   - load zero (takes priority over enable)
//   enable  - count one cycle
//   expired - high once TIMEOUT request cycles have been observed
// ---------------------------------------------------------------------------
module ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count equals the number of request cycles already completed, so
    // the current cycle is the TIMEOUT-th one when count == TIMEOUT-1. The
    // counter saturates there so it can never wrap back below the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//
// Purpose : Completes a vending transaction. Opens the product gate for one
//           cycle when an item was bought, then pays the change one coin at
//           a time through a four-phase req/ack handshake with the hopper.
//           A hopper that never acknowledges drives the block into a
//           terminal FAULT state; requests arriving while busy are dropped
//           and recorded in a sticky overrun flag.
//
// Parameters:
//   COIN_TK     - tk value of one hopper coin
//   ACK_TIMEOUT - max request cycles without coin_ack before FAULT
//   CNT_W       - width of the lifetime coin counter
//
// Ports:
//   clock        - rising-edge clock
//   reset        - asynchronous, active-low reset
//   vend_valid   - one-cycle strobe qualifying buy/chg
//   buy          - an item was purchased
//   chg          - change code (00=0, 01=5, 10=10, 11=15 tk)
//   coin_ack     - hopper acknowledge, high while ejecting a coin
//   item_release - one-cycle product gate pulse
//   coin_req     - request one coin from the hopper
//   busy         - dispenser not idle
//   owed_tk      - change still to be paid in this transaction
//   total_coins  - lifetime count of acknowledged coins (wraps)
//   overrun      - sticky: vend_valid seen while busy
//   fault        - sticky: hopper timed out
//
// Every output comes straight from a flop; nothing is combinational from
// the inputs.
// ---------------------------------------------------------------------------
module change_dispenser #(
    parameter int COIN_TK     = change_dispenser_pkg::COIN_TK,
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vend_valid,
    input  logic             buy,
    input  logic [1:0]       chg,
    input  logic             coin_ack,
    output logic             item_release,
    output logic             coin_req,
    output logic             busy,
    output logic [4:0]       owed_tk,
    output logic [CNT_W-1:0] total_coins,
    output logic             overrun,
    output logic             fault
);

    import change_dispenser_pkg::*;

    state_e           state_q;
    state_e           state_d;
    logic [1:0]       coins_left_q;
    logic [1:0]       coins_left_d;
    logic [4:0]       owed_q;
    logic [4:0]       owed_d;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] total_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             fault_q;
    logic             fault_d;
    logic             item_release_q;
    logic             item_release_d;
    logic             coin_req_q;
    logic             coin_req_d;
    logic             busy_q;
    logic             busy_d;

    logic             timer_clear;
    logic             timer_enable;
    logic             timer_expired;

    ack_timer #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next-state and datapath logic. coins_left doubles as the loop counter
    // for the coin handshake; it is only reloaded from chg in IDLE, so a
    // second vend_valid while busy cannot disturb the coins still owed.
    always_comb begin
        state_d      = state_q;
        coins_left_d = coins_left_q;
        owed_d       = owed_q;
        total_d      = total_q;
        overrun_d    = overrun_q;
        fault_d      = fault_q;

        case (state_q)
            IDLE: begin
                if (vend_valid) begin
                    coins_left_d = chg;
                    owed_d       = chg_to_tk(chg, COIN_TK);
                    if (buy) begin
                        state_d = RELEASE;
                    end else if (chg != R0) begin
                        state_d = REQ;
                    end
                end
            end

            RELEASE: begin
                state_d = (coins_left_q != 2'd0) ? REQ : IDLE;
            end

            // An acknowledge in the same cycle as the timeout still counts
            // as a delivered coin.
            REQ: begin
                if (coin_ack) begin
                    coins_left_d = coins_left_q - 2'd1;
                    owed_d       = owed_q - 5'(COIN_TK);
                    total_d      = total_q + 1'b1;
                    state_d      = WAIT_LOW;
                end else if (timer_expired) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end
            end

            // Second half of the four-phase handshake: the next request is
            // only raised after the hopper has released its acknowledge.
            WAIT_LOW: begin
                if (!coin_ack) begin
                    state_d = (coins_left_q != 2'd0) ? REQ : IDLE;
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Any strobe outside IDLE (including FAULT) is dropped and flagged.
        if (vend_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        // Outputs are decoded from the next state so that, once registered,
        // they line up exactly with the state they describe.
        item_release_d = (state_d == RELEASE);
        coin_req_d     = (state_d == REQ);
        busy_d         = (state_d != IDLE);
    end

    // The timer restarts on every entry to REQ, whether from IDLE, RELEASE
    // or WAIT_LOW, and runs for each cycle actually spent in REQ.
    assign timer_clear  = (state_d == REQ) && (state_q != REQ);
    assign timer_enable = (state_q == REQ);

    // State and registered outputs. Reset abandons any change still owed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            coins_left_q   <= '0;
            owed_q         <= '0;
            total_q        <= '0;
            overrun_q      <= 1'b0;
            fault_q        <= 1'b0;
            item_release_q <= 1'b0;
            coin_req_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            coins_left_q   <= coins_left_d;
            owed_q         <= owed_d;
            total_q        <= total_d;
            overrun_q      <= overrun_d;
            fault_q        <= fault_d;
            item_release_q <= item_release_d;
            coin_req_q     <= coin_req_d;
            busy_q         <= busy_d;
        end
    end

    assign item_release = item_release_q;
    assign coin_req     = coin_req_q;
    assign busy         = busy_q;
    assign owed_tk      = owed_q;
    assign total_coins  = total_q;
    assign overrun      = overrun_q;
    assign fault        = fault_q;

endmodule
